// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequenced ID-stage hazard controller.
//
// Detects load-use, flag-to-branch and register-to-branch-register hazards.
// When a hazard is seen, it loads the required stall length and sequences the
// stall itself. It also freezes the pipeline while a cache miss is in progress
// and flushes IF/ID on a taken branch. A saturating counter records how many
// cycles the unit inserted a bubble.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ifid_opcode      opcode of the instruction in ID
//   ifid_rs/rt       source registers of the ID instruction
//   idex_rd          destination of the EX instruction
//   idex_memread     EX instruction is a load
//   idex_regwrite    EX instruction writes a register
//   idex_flag_en     EX instruction updates the flags
//   exmem_rd         destination of the MEM instruction
//   exmem_regwrite   MEM instruction writes a register
//   branch_taken     branch resolved taken in ID
//   mem_busy         cache miss in progress, freeze the pipeline
//   pc_write_en      PC may update
//   ifid_write_en    IF/ID may load
//   idex_bubble      force ID/EX control fields to NOP
//   pipe_freeze      hold ID/EX, EX/MEM and MEM/WB
//   ifid_flush       clear IF/ID on the next edge
//   stall_cnt        saturating count of bubble cycles
module hazard_ctrl_seq #(
  parameter int unsigned     RA_W         = 4,
  parameter int unsigned     OP_W         = 4,
  parameter logic [OP_W-1:0] OPC_B        = 4'b1100,
  parameter logic [OP_W-1:0] OPC_BR       = 4'b1101,
  parameter int unsigned     ZERO_REG     = 1,
  parameter int unsigned     LU_STALL     = 1,
  parameter int unsigned     BR_EX_STALL  = 2,
  parameter int unsigned     BR_MEM_STALL = 1,
  parameter int unsigned     FLAG_STALL   = 1,
  parameter int unsigned     PCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   ifid_opcode,
  input  logic [RA_W-1:0]   ifid_rs,
  input  logic [RA_W-1:0]   ifid_rt,
  input  logic [RA_W-1:0]   idex_rd,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic              idex_flag_en,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              ifid_flush,
  output logic [PCNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_HAZ = 2'd1,
    S_MEM = 2'd2
  } state_t;

  localparam logic [2:0] LU_N  = 3'(LU_STALL);
  localparam logic [2:0] BE_N  = 3'(BR_EX_STALL);
  localparam logic [2:0] BM_N  = 3'(BR_MEM_STALL);
  localparam logic [2:0] FL_N  = 3'(FLAG_STALL);

  state_t              state_q, state_d;
  logic [2:0]          rem_q, rem_d;
  logic                ret_q, ret_d;     // 1: resume HAZ after a miss, 0: resume RUN
  logic [PCNT_W-1:0]   cnt_q, cnt_d;

  logic                haz_lu, haz_fl, haz_be, haz_bm;
  logic [2:0]          n_req;
  logic                eff_haz;
  logic                pc_we, ifid_we, bubble, freeze, flush;

  function automatic logic rd_ok(input logic [RA_W-1:0] x);
    return (x != '0) || (ZERO_REG == 0);
  endfunction

  assign haz_lu = idex_memread && rd_ok(idex_rd) &&
                  ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
  assign haz_fl = ((ifid_opcode == OPC_B) || (ifid_opcode == OPC_BR)) && idex_flag_en;
  assign haz_be = (ifid_opcode == OPC_BR) && idex_regwrite && rd_ok(idex_rd) &&
                  (idex_rd == ifid_rs);
  assign haz_bm = (ifid_opcode == OPC_BR) && exmem_regwrite && rd_ok(exmem_rd) &&
                  (exmem_rd == ifid_rs);

  // Longest stall demanded by any active hazard term.
  always_comb begin
    n_req = 3'd0;
    if (haz_lu && (LU_N > n_req)) n_req = LU_N;
    if (haz_fl && (FL_N > n_req)) n_req = FL_N;
    if (haz_be && (BE_N > n_req)) n_req = BE_N;
    if (haz_bm && (BM_N > n_req)) n_req = BM_N;
  end

  // A MEM state with the miss cleared acts as the state it interrupted.
  assign eff_haz = (state_q == S_HAZ) || ((state_q == S_MEM) && ret_q);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ret_d   = ret_q;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    bubble  = 1'b0;
    freeze  = 1'b0;
    flush   = 1'b0;

    if (mem_busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      freeze  = 1'b1;
      ret_d   = eff_haz;
      state_d = S_MEM;
    end else if (eff_haz) begin
      // Stall in progress: hazard terms are deliberately not re-evaluated.
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      rem_d   = rem_q - 3'd1;
      state_d = (rem_q == 3'd1) ? S_RUN : S_HAZ;
    end else if (n_req != 3'd0) begin
      // Hazard stall outranks a taken-branch flush.
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (n_req == 3'd1) begin
        rem_d   = 3'd0;
        state_d = S_RUN;
      end else begin
        rem_d   = n_req - 3'd1;
        state_d = S_HAZ;
      end
    end else begin
      flush   = branch_taken;
      state_d = S_RUN;
    end
  end

  assign cnt_d = (bubble && (cnt_q != {PCNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      rem_q   <= 3'd0;
      ret_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held,
  // so an asserted reset cancels any stall or freeze without waiting for a clock.
  assign pc_write_en   = rst_n ? pc_we   : 1'b1;
  assign ifid_write_en = rst_n ? ifid_we : 1'b1;
  assign idex_bubble   = rst_n ? bubble  : 1'b0;
  assign pipe_freeze   = rst_n ? freeze  : 1'b0;
  assign ifid_flush    = rst_n ? flush   : 1'b0;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
module tb_hazard_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ifid_opcode, ifid_rs, ifid_rt, idex_rd, exmem_rd;
  logic        idex_memread, idex_regwrite, idex_flag_en, exmem_regwrite;
  logic        branch_taken, mem_busy;
  logic        pc_write_en, ifid_write_en, idex_bubble, pipe_freeze, ifid_flush;
  logic [15:0] stall_cnt;
  logic        z_pc, z_ifid, z_bub, z_frz, z_fl;
  logic [15:0] z_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_flag_en(idex_flag_en), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt)
  );

  hazard_ctrl_seq #(.ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_flag_en(idex_flag_en), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write_en(z_pc), .ifid_write_en(z_ifid), .idex_bubble(z_bub),
    .pipe_freeze(z_frz), .ifid_flush(z_fl), .stall_cnt(z_cnt)
  );

  // Reference model: a count of bubbles still owed plus a saturating total.
  int   m_pend, m_cnt, m_n;
  logic e_pc, e_bub, e_frz, e_fl;
  logic s_pc, s_ifid, s_bub, s_frz, s_fl, s0_bub;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int req_n();
    int n = 0;
    if (idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt) && n < 1) n = 1;
    if ((ifid_opcode == 4'b1100 || ifid_opcode == 4'b1101) && idex_flag_en && n < 1) n = 1;
    if (ifid_opcode == 4'b1101 && idex_regwrite && idex_rd != 0 && idex_rd == ifid_rs && n < 2) n = 2;
    if (ifid_opcode == 4'b1101 && exmem_regwrite && exmem_rd != 0 && exmem_rd == ifid_rs && n < 1) n = 1;
    return n;
  endfunction

  task automatic model_eval();
    e_pc = 1; e_bub = 0; e_frz = 0; e_fl = 0; m_n = 0;
    if (!rst_n) begin
      m_pend = 0; m_cnt = 0;
    end else if (mem_busy) begin
      e_pc = 0; e_frz = 1;
    end else if (m_pend > 0) begin
      e_pc = 0; e_bub = 1;
    end else begin
      m_n = req_n();
      if (m_n > 0) begin e_pc = 0; e_bub = 1; end
      else e_fl = branch_taken;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_pend = 0; m_cnt = 0;
    end else if (!mem_busy) begin
      if (m_pend > 0) m_pend--;
      else if (m_n > 0) m_pend = m_n - 1;
      if (e_bub && m_cnt < 65535) m_cnt++;
    end
  endtask

  // One clock cycle with the current inputs, checked against the model.
  task automatic cycle(input string nm);
    @(negedge clk);
    model_eval();
    s_pc = pc_write_en; s_ifid = ifid_write_en; s_bub = idex_bubble;
    s_frz = pipe_freeze; s_fl = ifid_flush; s0_bub = z_bub;
    chk({nm, ".pc"},     32'(s_pc),   32'(e_pc));
    chk({nm, ".ifid"},   32'(s_ifid), 32'(e_pc));
    chk({nm, ".bubble"}, 32'(s_bub),  32'(e_bub));
    chk({nm, ".freeze"}, 32'(s_frz),  32'(e_frz));
    chk({nm, ".flush"},  32'(s_fl),   32'(e_fl));
    chk({nm, ".cnt"},    32'(stall_cnt), 32'(m_cnt));
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ifid_opcode = 0; ifid_rs = 0; ifid_rt = 0; idex_rd = 0; exmem_rd = 0;
    idex_memread = 0; idex_regwrite = 0; idex_flag_en = 0; exmem_regwrite = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic reset_all();
    rst_n = 0; idle();
    #2; rst_n = 1;
    m_pend = 0; m_cnt = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string      nm;
    logic [3:0] op, rs, rt, ird, erd;
    logic       mrd, rw, fe, ew, bt, mb;
    logic       x_pc, x_bub, x_frz, x_fl;
  } vec_t;
  vec_t vt[13];

  initial begin
    //           name       op       rs rt ird erd mrd rw fe ew bt mb  pc bub frz fl
    vt[0]  = '{"idle",     4'h0,    0, 0, 0,  0,  0,  0, 0, 0, 0, 0,  1, 0,  0,  0};
    vt[1]  = '{"lu_rt",    4'h0,    1, 3, 3,  0,  1,  1, 0, 0, 0, 0,  0, 1,  0,  0};
    vt[2]  = '{"lu_rs",    4'h0,    3, 1, 3,  0,  1,  1, 0, 0, 0, 0,  0, 1,  0,  0};
    vt[3]  = '{"lu_miss",  4'h0,    4, 5, 3,  0,  1,  1, 0, 0, 0, 0,  1, 0,  0,  0};
    vt[4]  = '{"lu_r0",    4'h0,    0, 0, 0,  0,  1,  1, 0, 0, 0, 0,  1, 0,  0,  0};
    vt[5]  = '{"fl_b",     4'b1100, 0, 0, 0,  0,  0,  0, 1, 0, 0, 0,  0, 1,  0,  0};
    vt[6]  = '{"fl_alu",   4'h0,    0, 0, 0,  0,  0,  0, 1, 0, 0, 0,  1, 0,  0,  0};
    vt[7]  = '{"be",       4'b1101, 5, 0, 5,  0,  0,  1, 0, 0, 0, 0,  0, 1,  0,  0};
    vt[8]  = '{"be_b_op",  4'b1100, 5, 0, 5,  0,  0,  1, 0, 0, 0, 0,  1, 0,  0,  0};
    vt[9]  = '{"bm",       4'b1101, 7, 0, 0,  7,  0,  0, 0, 1, 0, 0,  0, 1,  0,  0};
    vt[10] = '{"br_flush", 4'b1100, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0,  1, 0,  0,  1};
    vt[11] = '{"br_vs_fl", 4'b1100, 0, 0, 0,  0,  0,  0, 1, 0, 1, 0,  0, 1,  0,  0};
    vt[12] = '{"busy_lu",  4'h0,    3, 3, 3,  0,  1,  1, 0, 0, 1, 1,  0, 0,  1,  0};

    // Reset values with a hazard present on the inputs.
    idle(); rst_n = 0;
    idex_memread = 1; idex_rd = 3; ifid_rt = 3; branch_taken = 1;
    #3;
    chk("rst.pc", 32'(pc_write_en), 1);
    chk("rst.ifid", 32'(ifid_write_en), 1);
    chk("rst.bubble", 32'(idex_bubble), 0);
    chk("rst.freeze", 32'(pipe_freeze), 0);
    chk("rst.flush", 32'(ifid_flush), 0);
    chk("rst.cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    reset_all();

    // Table-driven single-cycle checks from a fresh RUN state.
    for (int i = 0; i < 13; i++) begin
      reset_all();
      ifid_opcode = vt[i].op; ifid_rs = vt[i].rs; ifid_rt = vt[i].rt;
      idex_rd = vt[i].ird; exmem_rd = vt[i].erd; idex_memread = vt[i].mrd;
      idex_regwrite = vt[i].rw; idex_flag_en = vt[i].fe; exmem_regwrite = vt[i].ew;
      branch_taken = vt[i].bt; mem_busy = vt[i].mb;
      @(negedge clk);
      chk({vt[i].nm, ".pc"}, 32'(pc_write_en), 32'(vt[i].x_pc));
      chk({vt[i].nm, ".ifid"}, 32'(ifid_write_en), 32'(vt[i].x_pc));
      chk({vt[i].nm, ".bubble"}, 32'(idex_bubble), 32'(vt[i].x_bub));
      chk({vt[i].nm, ".freeze"}, 32'(pipe_freeze), 32'(vt[i].x_frz));
      chk({vt[i].nm, ".flush"}, 32'(ifid_flush), 32'(vt[i].x_fl));
      @(posedge clk); #1;
    end

    // Load-use: one bubble, then free-running.
    reset_all();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 3; ifid_rt = 3;
    cycle("lu1");  chk("lu1.bub", 32'(s_bub), 1);
    idle();
    cycle("lu2");  chk("lu2.pc", 32'(s_pc), 1);
    chk("lu.cnt", 32'(stall_cnt), 1);

    // BR after ALU write: two bubbles, second one with hazard inputs removed.
    reset_all();
    ifid_opcode = 4'b1101; ifid_rs = 5; idex_regwrite = 1; idex_rd = 5; idex_flag_en = 1;
    cycle("be1");  chk("be1.bub", 32'(s_bub), 1);
    idle();
    cycle("be2");  chk("be2.bub", 32'(s_bub), 1);
    cycle("be3");  chk("be3.pc", 32'(s_pc), 1);
    chk("be.cnt", 32'(stall_cnt), 2);

    // Zero register: no stall with ZERO_REG=1, one-cycle stall with ZERO_REG=0.
    reset_all();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 0; ifid_rs = 0;
    cycle("zr");
    chk("zr1.bub", 32'(s_bub), 0);
    chk("zr0.bub", 32'(s0_bub), 1);
    idle();
    @(negedge clk);
    chk("zr0.after", 32'(z_bub), 0);
    chk("zr0.cnt", 32'(z_cnt), 1);
    @(posedge clk); #1;

    // Miss during a BE stall: freeze holds the remaining bubble.
    reset_all();
    ifid_opcode = 4'b1101; ifid_rs = 5; idex_regwrite = 1; idex_rd = 5;
    cycle("ms0");
    idle(); mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      cycle("ms_busy");
      chk("ms_busy.frz", 32'(s_frz), 1);
      chk("ms_busy.bub", 32'(s_bub), 0);
    end
    mem_busy = 0;
    cycle("ms_resume"); chk("ms_resume.bub", 32'(s_bub), 1);
    cycle("ms_done");   chk("ms_done.pc", 32'(s_pc), 1);
    chk("ms.cnt", 32'(stall_cnt), 2);

    // Taken branch against a flag hazard.
    reset_all();
    ifid_opcode = 4'b1100; idex_flag_en = 1; branch_taken = 1;
    cycle("bf_stall"); chk("bf_stall.flush", 32'(s_fl), 0);
    idex_flag_en = 0;
    cycle("bf_go");    chk("bf_go.flush", 32'(s_fl), 1);
    branch_taken = 0;
    cycle("bf_end");   chk("bf_end.flush", 32'(s_fl), 0);

    // Asynchronous reset in the middle of a HAZ stall.
    reset_all();
    ifid_opcode = 4'b1101; ifid_rs = 5; idex_regwrite = 1; idex_rd = 5;
    cycle("ar0");
    #1; rst_n = 0; #1;
    chk("ar.pc", 32'(pc_write_en), 1);
    chk("ar.bubble", 32'(idex_bubble), 0);
    chk("ar.freeze", 32'(pipe_freeze), 0);
    chk("ar.cnt", 32'(stall_cnt), 0);
    idle();
    @(posedge clk); #1;
    rst_n = 1; m_pend = 0; m_cnt = 0;
    cycle("ar_after"); chk("ar_after.pc", 32'(s_pc), 1);

    // Randomized traffic against the model.
    reset_all();
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_n = ($urandom_range(0, 63) != 0);
      r = $urandom_range(0, 3);
      ifid_opcode = (r == 0) ? 4'b1100 : (r == 1) ? 4'b1101 : 4'($urandom_range(0, 15));
      ifid_rs = 4'($urandom_range(0, 3)); ifid_rt = 4'($urandom_range(0, 3));
      idex_rd = 4'($urandom_range(0, 3)); exmem_rd = 4'($urandom_range(0, 3));
      idex_memread = ($urandom_range(0, 2) == 0);
      idex_regwrite = ($urandom_range(0, 1) == 0);
      idex_flag_en = ($urandom_range(0, 2) == 0);
      exmem_regwrite = ($urandom_range(0, 1) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end
    rst_n = 1;

    // Saturation: a continuous flag stall drives the counter to all-ones.
    reset_all();
    ifid_opcode = 4'b1100; idex_flag_en = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat.cnt", 32'(stall_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat.hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat.bub", 32'(idex_bubble), 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
